// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: 7-bit PWM LED driver with immediate or fading duty updates.
// Each duty_valid byte either sets the duty at once (bit7 = 0) or starts or
// retargets a linear fade (bit7 = 1) that moves one LSB every STEP_DIV cycles.
module pwm_fade_ctrl #(
  parameter int unsigned STEP_DIV = 64
) (
  input  logic       clk_100khz,
  input  logic       rst_n,
  input  logic       duty_valid,
  input  logic [7:0] duty_byte,
  output logic       led_pwm,
  output logic [6:0] duty_cur,
  output logic       busy
);

  localparam int unsigned PW_RAW = $clog2(STEP_DIV + 1);
  localparam int unsigned PW     = (PW_RAW < 1) ? 1 : PW_RAW;
  localparam logic [PW-1:0] PRE_TC = PW'(STEP_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t        state_q;
  logic [6:0]    pwm_cnt_q;
  logic [6:0]    duty_act_q;
  logic [6:0]    duty_cur_q;
  logic [6:0]    target_q;
  logic [PW-1:0] prescale_q;
  logic          led_q;

  logic [6:0]    step_d;
  logic          fade_req;
  logic [6:0]    byte_duty;

  assign fade_req  = duty_byte[7];
  assign byte_duty = duty_byte[6:0];

  // One LSB toward the target; only consulted while a fade is active and
  // target differs from duty_cur, so it can never overshoot or wrap.
  always_comb begin
    step_d = duty_cur_q;
    if (duty_cur_q < target_q) begin
      step_d = duty_cur_q + 7'd1;
    end else if (duty_cur_q > target_q) begin
      step_d = duty_cur_q - 7'd1;
    end
  end

  // Free-running PWM counter, period-aligned compare load, registered output.
  always_ff @(posedge clk_100khz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q  <= '0;
      duty_act_q <= '0;
      led_q      <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 7'd1;
      led_q     <= (pwm_cnt_q < duty_act_q);
      if (pwm_cnt_q == 7'd127) begin
        duty_act_q <= duty_cur_q;
      end
    end
  end

  // Fade FSM: a new byte always wins over a coincident prescaler step.
  always_ff @(posedge clk_100khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      duty_cur_q <= '0;
      target_q   <= '0;
      prescale_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (duty_valid) begin
            if (!fade_req) begin
              duty_cur_q <= byte_duty;
            end else if (byte_duty != duty_cur_q) begin
              target_q   <= byte_duty;
              prescale_q <= '0;
              state_q    <= RAMP;
            end
          end
        end
        RAMP: begin
          // The prescaler keeps running through a retarget so the step
          // cadence is not reset by mid-fade writes.
          if (prescale_q == PRE_TC) begin
            prescale_q <= '0;
          end else begin
            prescale_q <= prescale_q + PW'(1);
          end

          if (duty_valid) begin
            if (!fade_req) begin
              duty_cur_q <= byte_duty;
              state_q    <= IDLE;
            end else begin
              target_q <= byte_duty;
              if (byte_duty == duty_cur_q) begin
                state_q <= IDLE;
              end
            end
          end else if (prescale_q == PRE_TC) begin
            duty_cur_q <= step_d;
            if (step_d == target_q) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led_pwm  = led_q;
  assign duty_cur = duty_cur_q;
  assign busy     = (state_q == RAMP);

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter: STEP_DIV, 64, clk_100khz cycles per one-LSB duty step during a fade; legal range 1..65535.
REQ-002 Port: clk_100khz  input  1  single clock for all logic.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: duty_valid  input  1  one-cycle strobe; duty_byte is valid this cycle.
REQ-005 Port: duty_byte  input  8  bit7 = fade request (1 = fade, 0 = immediate); bits6:0 = target duty, 0..127.
REQ-006 Port: led_pwm  output  1  registered PWM output.
REQ-007 Port: duty_cur  output  7  current commanded duty.
REQ-008 Port: busy  output  1  high while a fade is in progress.

Function
REQ-009 The block SHALL sit downstream of the SPI byte receiver; each received byte arrives as one duty_valid pulse.
REQ-010 The PWM counter SHALL be 7 bits, free-running, increment every cycle, and wrap 127->0 (period 128 cycles).
REQ-011 duty_act (active compare) SHALL load duty_cur only on the cycle where pwm_cnt == 127, so period changes are glitch-free.
REQ-012 Each cycle, led_pwm SHALL register (pwm_cnt < duty_act) using pre-edge values: duty 0 gives constant low; duty 127 gives 127 high cycles and 1 low cycle per period.
REQ-013 The FSM SHALL have exactly two states: IDLE and RAMP; busy = (state == RAMP).
REQ-014 IDLE, duty_valid, bit7=0: duty_cur SHALL become duty_byte[6:0] on the next edge; state stays IDLE.
REQ-015 IDLE, duty_valid, bit7=1, target != duty_cur: latch target, clear prescaler, go RAMP on the next edge.
REQ-016 IDLE, duty_valid, bit7=1, target == duty_cur: no state change, no duty change.
REQ-017 RAMP: the prescaler SHALL count 0..STEP_DIV-1. At terminal count it wraps to 0 and duty_cur moves one LSB toward target.
REQ-018 The edge that makes duty_cur equal target SHALL also return the state to IDLE; duty_cur SHALL never overshoot target and never wrap.
REQ-019 RAMP, duty_valid, bit7=1: retarget. The prescaler is not cleared and direction is re-evaluated. If the new target == duty_cur, go IDLE on the next edge.
REQ-020 RAMP, duty_valid, bit7=0: abort the fade, set duty_cur to the byte value, and go IDLE on the next edge.
REQ-021 Duty_valid coinciding with a prescaler terminal count SHALL give priority to the new byte; the step is discarded that cycle.
REQ-022 Fade timing: a fade of |target - start| = D steps SHALL complete exactly D*STEP_DIV cycles after the edge that enters RAMP.
REQ-023 duty_byte SHALL be ignored whenever duty_valid is low.
REQ-024 STEP_DIV = 1 SHALL step every cycle; the prescaler width SHALL be $clog2(STEP_DIV+1), minimum 1 bit.

Reset
REQ-025 When rst_n is low, the block SHALL asynchronously force state = IDLE and zero pwm_cnt, prescaler, target, duty_cur, duty_act, led_pwm and busy.
REQ-026 Reset asserted mid-fade SHALL abandon the fade; after release the block behaves as freshly reset.
REQ-027 Release of rst_n is synchronous to clk_100khz; the first pwm_cnt increment occurs on the first edge after release.

Verification (bench uses STEP_DIV = 4)
REQ-028 Immediate write: duty_valid with 0x40 -> duty_cur = 64 one cycle later, busy stays 0, and after the next pwm_cnt == 127 led_pwm is high for 64 of 128 cycles.
REQ-029 Fade up: from duty 0, write 0x8A (fade to 10) -> busy high for 40 cycles, duty_cur increments every 4 cycles, ends at 10, busy drops on the same edge.
REQ-030 Retarget down: during a fade 0->100 at duty_cur 20, write 0x85 -> direction reverses, duty_cur decrements to 5, and busy then clears.
REQ-031 Abort: during a fade, write 0x7F -> duty_cur = 127 next cycle, busy = 0, and led_pwm shows 127 high / 1 low per period.
REQ-032 Boundaries: write 0x00 gives led_pwm constant low. A fade write equal to the current duty leaves busy = 0. A write coincident with a terminal count leaves the step discarded.
REQ-033 Reset mid-fade: assert rst_n low at duty_cur 37 -> all outputs 0 immediately, without waiting for a clock edge.
